// File: rtl/accum_dump_ctrl_pkg.sv
// Shared widths, FSM state type and helpers for the accumulator dump path.
// Every module in this slice imports this package.
package accum_dump_ctrl_pkg;

  localparam int AXIS_DATA_W      = 512;
  localparam int ENTRY_W          = 64;
  localparam int ENTRIES_PER_BEAT = 8;
  localparam int BEAT_BYTES       = 64;
  localparam int XFER_MAX_BYTES   = 256;
  localparam int LANE_W           = $clog2(ENTRIES_PER_BEAT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_FILL,
    ST_SEND,
    ST_WAIT_DONE
  } dump_state_t;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/accum_dump_ctrl_if.sv
// Write-master facing bundle: transaction control plus the AXI-Stream data beat.
// The dump controller uses the master modport, the write master the slave modport.
interface accum_dump_ctrl_if;
  import accum_dump_ctrl_pkg::*;

  logic                   ctrl_start;
  logic                   ctrl_done;
  logic [63:0]            ctrl_addr_offset;
  logic [63:0]            ctrl_xfer_size_in_bytes;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic [AXIS_DATA_W-1:0] m_axis_tdata;
  logic                   m_axis_tlast;

  modport master (
    output ctrl_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes,
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    input  ctrl_done, m_axis_tready
  );

  modport slave (
    input  ctrl_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    output ctrl_done, m_axis_tready
  );

endinterface

// File: rtl/accum_dump_ctrl_beat_packer.sv
// 8 x 64-bit lane register filled from accum_array read data, with a valid/lane-tag
// pipe that tracks each read through the RAM's read latency.
module accum_dump_ctrl_beat_packer
  import accum_dump_ctrl_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en_i,
  input  logic [LANE_W-1:0]      rd_lane_i,
  input  logic [ENTRY_W-1:0]     rd_data_i,
  input  logic                   clear_i,
  output logic [AXIS_DATA_W-1:0] beat_o,
  output logic [LANE_W:0]        fill_cnt_o
);

  logic              vld_q [RD_LATENCY];
  logic [LANE_W-1:0] tag_q [RD_LATENCY];
  logic [ENTRY_W-1:0] lane_q [ENTRIES_PER_BEAT];
  logic [LANE_W:0]    fill_q;
  logic               wr_v;
  logic [LANE_W-1:0]  wr_lane;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q[0] <= 1'b0;
      tag_q[0] <= '0;
    end else begin
      vld_q[0] <= rd_en_i;
      tag_q[0] <= rd_lane_i;
    end
  end

  generate
    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q[gi] <= 1'b0;
          tag_q[gi] <= '0;
        end else begin
          vld_q[gi] <= vld_q[gi-1];
          tag_q[gi] <= tag_q[gi-1];
        end
      end
    end
  endgenerate

  // The last pipe stage lines up with the cycle the RAM presents its data.
  assign wr_v    = vld_q[RD_LATENCY-1];
  assign wr_lane = tag_q[RD_LATENCY-1];

  generate
    for (genvar gi = 0; gi < ENTRIES_PER_BEAT; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (reset || clear_i) begin
          lane_q[gi] <= '0;
        end else if (wr_v && (wr_lane == LANE_W'(gi))) begin
          lane_q[gi] <= rd_data_i;
        end
      end
      assign beat_o[gi*ENTRY_W +: ENTRY_W] = lane_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      fill_q <= '0;
    end else if (wr_v) begin
      fill_q <= fill_q + 1'b1;
    end
  end

  assign fill_cnt_o = fill_q;

endmodule

// File: rtl/accum_dump_ctrl.sv
// Dumps N 64-bit accumulators from accum_array to the AXI write master, eight per
// 512-bit beat, in write transactions of at most MAX_ENTRIES entries.
module accum_dump_ctrl
  import accum_dump_ctrl_pkg::*;
#(
  parameter int MAX_ENTRIES      = XFER_MAX_BYTES / ENTRY_W * ENTRY_W / 8,
  parameter int ACCUM_RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                kick_i,
  output logic                busy_o,
  input  logic [31:0]         num_of_entries_i,
  input  logic [63:0]         memory_offset_i,
  accum_dump_ctrl_if.master   wr_if,
  output logic [31:0]         accum_rd_addr_o,
  output logic                accum_rd_en_o,
  input  logic [ENTRY_W-1:0]  accum_rd_dout_i
);

  dump_state_t state_q;
  logic        busy_q, start_q, tvalid_q, tlast_q, rd_en_q, done_q;
  logic [63:0] addr_q, size_q, offset_q;
  logic [31:0] rd_addr_q, remaining_q, rd_ptr_q, chunk_q, beats_q, beat_idx_q, chunk_left_q;
  logic [LANE_W:0] issued_q, target_q;

  logic [31:0]     chunk_d, beats_d;
  logic [LANE_W:0] target_d, fill_cnt;
  logic            accept_d, last_beat_d;

  assign chunk_d  = min_u32(remaining_q, 32'(MAX_ENTRIES));
  assign beats_d  = (chunk_d + 32'(ENTRIES_PER_BEAT - 1)) >> LANE_W;
  assign target_d = (chunk_left_q >= 32'(ENTRIES_PER_BEAT)) ? (LANE_W+1)'(ENTRIES_PER_BEAT)
                                                            : chunk_left_q[LANE_W:0];
  assign accept_d    = (state_q == ST_SEND) && tvalid_q && wr_if.m_axis_tready;
  assign last_beat_d = ((beat_idx_q + 32'd1) == beats_q);

  // Lane comes from the registered read address, so it is the global entry index mod 8.
  accum_dump_ctrl_beat_packer #(
    .RD_LATENCY(ACCUM_RD_LATENCY)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .rd_en_i   (rd_en_q),
    .rd_lane_i (rd_addr_q[LANE_W-1:0]),
    .rd_data_i (accum_rd_dout_i),
    .clear_i   (accept_d),
    .beat_o    (wr_if.m_axis_tdata),
    .fill_cnt_o(fill_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      offset_q     <= '0;
      rd_addr_q    <= '0;
      remaining_q  <= '0;
      rd_ptr_q     <= '0;
      chunk_q      <= '0;
      beats_q      <= '0;
      beat_idx_q   <= '0;
      chunk_left_q <= '0;
      issued_q     <= '0;
      target_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (kick_i) begin
            remaining_q <= num_of_entries_i;
            offset_q    <= memory_offset_i;
            rd_ptr_q    <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (remaining_q == 32'd0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            chunk_q      <= chunk_d;
            chunk_left_q <= chunk_d;
            beats_q      <= beats_d;
            beat_idx_q   <= '0;
            addr_q       <= offset_q;
            size_q       <= 64'(beats_d) * 64'(BEAT_BYTES);
            start_q      <= 1'b1;
            state_q      <= ST_START;
          end
        end
        ST_START: begin
          start_q  <= 1'b0;
          done_q   <= wr_if.ctrl_done;
          issued_q <= '0;
          target_q <= target_d;
          state_q  <= ST_FILL;
        end
        ST_FILL: begin
          if (wr_if.ctrl_done) done_q <= 1'b1;
          if (issued_q != target_q) begin
            rd_en_q      <= 1'b1;
            rd_addr_q    <= rd_ptr_q;
            rd_ptr_q     <= rd_ptr_q + 32'd1;
            issued_q     <= issued_q + 1'b1;
            chunk_left_q <= chunk_left_q - 32'd1;
          end else begin
            rd_en_q <= 1'b0;
            if (fill_cnt == target_q) begin
              tvalid_q <= 1'b1;
              tlast_q  <= last_beat_d;
              state_q  <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (wr_if.ctrl_done) done_q <= 1'b1;
          if (accept_d) begin
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            beat_idx_q <= beat_idx_q + 32'd1;
            if (last_beat_d) begin
              state_q <= ST_WAIT_DONE;
            end else begin
              issued_q <= '0;
              target_q <= target_d;
              state_q  <= ST_FILL;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (done_q) begin
            done_q      <= 1'b0;
            offset_q    <= offset_q + size_q;
            remaining_q <= remaining_q - chunk_q;
            state_q     <= ST_SETUP;
          end else if (wr_if.ctrl_done) begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o                        = busy_q;
  assign wr_if.ctrl_start              = start_q;
  assign wr_if.ctrl_addr_offset        = addr_q;
  assign wr_if.ctrl_xfer_size_in_bytes = size_q;
  assign wr_if.m_axis_tvalid           = tvalid_q;
  assign wr_if.m_axis_tlast            = tlast_q;
  assign accum_rd_addr_o               = rd_addr_q;
  assign accum_rd_en_o                 = rd_en_q;

endmodule

// File: tb/tb_accum_dump_ctrl.sv
// Bench for accum_dump_ctrl: two instances (read latency 1 and 3) share stimulus;
// each has its own RAM model, write-master responder and transaction logger.
module tb_accum_dump_ctrl;

  localparam int NI   = 2;
  localparam int RCAP = 1024;
  localparam int BCAP = 256;
  localparam int XCAP = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        kick = 1'b0;
  logic [31:0] num = '0;
  logic [63:0] off = '0;
  int          ready_pct = 100;
  bit          done_early = 1'b0;

  always #5 clk = ~clk;

  logic         busy_w   [NI];
  logic         tvalid_w [NI];
  logic         any_out_w[NI];
  logic [63:0]  x_addr [NI][XCAP];
  logic [63:0]  x_size [NI][XCAP];
  logic [511:0] b_data [NI][BCAP];
  logic         b_last [NI][BCAP];
  logic [31:0]  r_addr [NI][RCAP];
  int x_n[NI], b_n[NI], r_n[NI], stall_err[NI];
  int bx[NI], bb[NI], br[NI], bs[NI];
  int n_pass = 0, n_total = 0;

  function automatic logic [63:0] entry(input logic [31:0] a);
    return {16'hC0DE, a[15:0], ~a};
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int L = (gi == 0) ? 1 : 3;
      accum_dump_ctrl_if bus();
      logic [31:0]  rd_addr;
      logic         rd_en, busy_l, ready_r, done_r, stalled, pl;
      logic [63:0]  rd_dout;
      logic [63:0]  dpipe [L];
      logic [511:0] pd;
      int           cd = 0;

      accum_dump_ctrl #(.MAX_ENTRIES(32), .ACCUM_RD_LATENCY(L)) dut (
        .clk             (clk),
        .reset           (reset),
        .kick_i          (kick),
        .busy_o          (busy_l),
        .num_of_entries_i(num),
        .memory_offset_i (off),
        .wr_if           (bus),
        .accum_rd_addr_o (rd_addr),
        .accum_rd_en_o   (rd_en),
        .accum_rd_dout_i (rd_dout)
      );

      assign bus.m_axis_tready = ready_r;
      assign bus.ctrl_done     = done_r;
      assign busy_w[gi]        = busy_l;
      assign tvalid_w[gi]      = bus.m_axis_tvalid;
      assign any_out_w[gi]     = busy_l | rd_en | (|rd_addr) | bus.ctrl_start | (|bus.ctrl_addr_offset)
                               | (|bus.ctrl_xfer_size_in_bytes) | bus.m_axis_tvalid | bus.m_axis_tlast
                               | (|bus.m_axis_tdata);

      // RAM model: garbage on the bus whenever no read was issued L cycles ago.
      always @(posedge clk) begin
        dpipe[0] <= rd_en ? entry(rd_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
        for (int k = 1; k < L; k++) dpipe[k] <= dpipe[k-1];
      end
      assign rd_dout = dpipe[L-1];

      always @(posedge clk) begin
        ready_r <= (int'($urandom_range(99)) < ready_pct);
        done_r  <= 1'b0;
        if (reset) begin
          cd <= 0;
        end else begin
          if (cd == 1) done_r <= 1'b1;
          if (cd > 0) cd <= cd - 1;
          if (bus.ctrl_start && done_early) cd <= 3;
          if (bus.m_axis_tvalid && ready_r && bus.m_axis_tlast && !done_early) cd <= 2;
        end
      end

      always @(negedge clk) begin
        if (reset) begin
          stalled <= 1'b0;
        end else begin
          if (stalled && (!bus.m_axis_tvalid || bus.m_axis_tdata !== pd || bus.m_axis_tlast !== pl))
            stall_err[gi] <= stall_err[gi] + 1;
          stalled <= bus.m_axis_tvalid && !ready_r;
          pd      <= bus.m_axis_tdata;
          pl      <= bus.m_axis_tlast;
          if (bus.m_axis_tvalid && ready_r) begin
            b_data[gi][b_n[gi] % BCAP] <= bus.m_axis_tdata;
            b_last[gi][b_n[gi] % BCAP] <= bus.m_axis_tlast;
            b_n[gi] <= b_n[gi] + 1;
          end
          if (bus.ctrl_start) begin
            x_addr[gi][x_n[gi] % XCAP] <= bus.ctrl_addr_offset;
            x_size[gi][x_n[gi] % XCAP] <= bus.ctrl_xfer_size_in_bytes;
            x_n[gi] <= x_n[gi] + 1;
          end
          if (rd_en) begin
            r_addr[gi][r_n[gi] % RCAP] <= rd_addr;
            r_n[gi] <= r_n[gi] + 1;
          end
        end
      end
    end
  endgenerate

  task automatic chk(input string name, input int inst, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %h expected %h", name, inst, act, exp);
  endtask

  task automatic run(input int n, input logic [63:0] o, input int pct, input bit early,
                     input bit extra_kick, output int cyc);
    ready_pct  = pct;
    done_early = early;
    for (int i = 0; i < NI; i++) begin
      bx[i] = x_n[i]; bb[i] = b_n[i]; br[i] = r_n[i]; bs[i] = stall_err[i];
    end
    @(negedge clk);
    num = n; off = o; kick = 1'b1;
    @(negedge clk);
    kick = 1'b0; num = 32'h0000_FFFF; off = '1;
    cyc = 0;
    while ((busy_w[0] || busy_w[1]) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      kick = extra_kick && (cyc == 20);
    end
    kick = 1'b0;
    chk("busy_timeout", 0, cyc < 6000, 1'b1);
  endtask

  task automatic check_run(input int n, input logic [63:0] o, input int exp_x, input int exp_b);
    for (int i = 0; i < NI; i++) begin
      int rem = n, ent = 0, xi = 0, bi = 0, bad = 0;
      logic [63:0] a = o;
      while (rem > 0) begin
        int c  = (rem < 32) ? rem : 32;
        int nb = (c + 7) / 8;
        chk("xfer_addr", i, x_addr[i][(bx[i] + xi) % XCAP], a);
        chk("xfer_size", i, x_size[i][(bx[i] + xi) % XCAP], 64'(nb * 64));
        for (int b = 0; b < nb; b++) begin
          logic [511:0] e = '0;
          for (int k = 0; k < 8; k++)
            if (8*b + k < c) e[64*k +: 64] = entry(32'(ent + 8*b + k));
          chk("beat_data", i, b_data[i][(bb[i] + bi) % BCAP], e);
          chk("beat_last", i, b_last[i][(bb[i] + bi) % BCAP], (b == nb - 1));
          bi++;
        end
        ent += c; a += 64'(nb * 64); rem -= c; xi++;
      end
      chk("xfer_count", i, x_n[i] - bx[i], exp_x);
      chk("beat_count", i, b_n[i] - bb[i], exp_b);
      chk("rd_count", i, r_n[i] - br[i], n);
      for (int j = 0; j < n && j < r_n[i] - br[i]; j++)
        if (r_addr[i][(br[i] + j) % RCAP] != 32'(j)) bad++;
      chk("rd_order", i, bad, 0);
      chk("stall_stable", i, stall_err[i] - bs[i], 0);
    end
  endtask

  typedef struct {
    int          n;
    logic [63:0] off;
    int          pct;
    bit          early;
    int          exp_x;
    int          exp_b;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc;
    vecs[0] = '{5,  64'h0,    100, 1'b0, 1, 1};
    vecs[1] = '{32, 64'h40,   100, 1'b0, 1, 4};
    vecs[2] = '{70, 64'h1000, 100, 1'b0, 3, 9};
    vecs[3] = '{16, 64'h200,  30,  1'b0, 1, 2};
    vecs[4] = '{0,  64'h300,  100, 1'b0, 0, 0};
    vecs[5] = '{5,  64'h0,    100, 1'b1, 1, 1};
    vecs[6] = '{32, 64'h40,   100, 1'b1, 1, 4};
    vecs[7] = '{70, 64'h1000, 60,  1'b1, 3, 9};

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) chk("reset_outputs", i, any_out_w[i], 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      run(vecs[v].n, vecs[v].off, vecs[v].pct, vecs[v].early, 1'b0, cyc);
      check_run(vecs[v].n, vecs[v].off, vecs[v].exp_x, vecs[v].exp_b);
      if (vecs[v].n == 0) chk("n0_busy_cycles", 0, cyc <= 3, 1'b1);
      $display("vector %0d: N=%0d off=0x%0h early=%0d done in %0d cycles", v, vecs[v].n, vecs[v].off, vecs[v].early, cyc);
    end

    // A second kick while busy must not restart or extend the dump.
    run(32, 64'h80, 100, 1'b0, 1'b1, cyc);
    check_run(32, 64'h80, 1, 4);
    $display("kick-while-busy: N=32 done in %0d cycles", cyc);

    // Reset in the middle of a long dump, while instance 0 is presenting a beat.
    ready_pct = 50; done_early = 1'b0;
    for (int i = 0; i < NI; i++) bb[i] = b_n[i];
    @(negedge clk);
    num = 70; off = 64'h1000; kick = 1'b1;
    @(negedge clk);
    kick = 1'b0;
    cyc = 0;
    while (!(b_n[0] - bb[0] >= 5 && tvalid_w[0]) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("send_reached", 0, cyc < 2000, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("midrun_reset_outputs", i, any_out_w[i], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("mid-run reset applied after %0d cycles", cyc);

    run(8, 64'h40, 100, 1'b0, 1'b0, cyc);
    check_run(8, 64'h40, 1, 1);
    $display("post-reset: N=8 done in %0d cycles", cyc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
